// File: rtl/alu.sv
// Registered 4-bit-default integer ALU: {carry, result, zero} one cycle after A/B/opcode.
// Optional build macro ALU_SAT_EN makes ADD/SUB saturate instead of wrapping.
module alu #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       opcode,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] result_nxt;
    logic             carry_nxt;
    logic             zero_nxt;

    // The extra top bit of diff is the borrow when A < B.
    assign sum  = {1'b0, A} + {1'b0, B};
    assign diff = {1'b0, A} - {1'b0, B};

    always_comb begin
        result_nxt = '0;
        carry_nxt  = 1'b0;
        unique case (opcode)
            OP_ADD: begin
                carry_nxt  = sum[WIDTH];
                result_nxt = sum[WIDTH-1:0];
`ifdef ALU_SAT_EN
                if (sum[WIDTH]) result_nxt = '1;
`endif
            end
            OP_SUB: begin
                carry_nxt  = diff[WIDTH];
                result_nxt = diff[WIDTH-1:0];
`ifdef ALU_SAT_EN
                if (diff[WIDTH]) result_nxt = '0;
`endif
            end
            OP_AND: result_nxt = A & B;
            OP_OR:  result_nxt = A | B;
            OP_XOR: result_nxt = A ^ B;
            OP_NOT: result_nxt = ~A;
            OP_SHL: begin
                result_nxt = {A[WIDTH-2:0], 1'b0};
                carry_nxt  = A[WIDTH-1];
            end
            OP_SHR: begin
                result_nxt = {1'b0, A[WIDTH-1:1]};
                carry_nxt  = A[0];
            end
            default: begin
                result_nxt = '0;
                carry_nxt  = 1'b0;
            end
        endcase
    end

    // zero follows the final (possibly saturated) result.
    assign zero_nxt = (result_nxt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b1;
        end else begin
            result <= result_nxt;
            carry  <= carry_nxt;
            zero   <= zero_nxt;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: the driver queues expected outputs, the monitor pops one per edge.
module tb_alu;

    typedef struct {
        logic [3:0] r;
        logic       c;
        logic       z;
        string      name;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] opcode;
    logic [3:0] result;
    logic       zero;
    logic       carry;
    logic       clk_en;

    int   n_checks;
    int   n_errors;
    exp_t sb_q[$];

    alu #(.WIDTH(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .A      (a),
        .B      (b),
        .opcode (opcode),
        .result (result),
        .zero   (zero),
        .carry  (carry)
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    // Reference behaviour written with integer arithmetic rather than bit slicing.
    function automatic exp_t model(input int av, input int bv, input int op, input string nm);
        exp_t e;
        int   s;
        int   r;
        int   c;
        r = 0;
        c = 0;
        case (op)
            0: begin
                s = av + bv;
                c = (s > 15) ? 1 : 0;
                r = s % 16;
`ifdef ALU_SAT_EN
                if (c == 1) r = 15;
`endif
            end
            1: begin
                c = (av < bv) ? 1 : 0;
                r = (av - bv + 16) % 16;
`ifdef ALU_SAT_EN
                if (c == 1) r = 0;
`endif
            end
            2: r = av & bv;
            3: r = av | bv;
            4: r = av ^ bv;
            5: r = 15 - av;
            6: begin
                r = (av * 2) % 16;
                c = (av >= 8) ? 1 : 0;
            end
            default: begin
                r = av / 2;
                c = av % 2;
            end
        endcase
        e.r    = 4'(r);
        e.c    = (c != 0);
        e.z    = (r == 0);
        e.name = nm;
        return e;
    endfunction

    task automatic issue(input int av, input int bv, input int op, input string nm);
        @(negedge clk);
        a      = 4'(av);
        b      = 4'(bv);
        opcode = 3'(op);
        sb_q.push_back(model(av, bv, op, nm));
    endtask

    task automatic check_now(input string nm, input logic [3:0] er, input logic ec, input logic ez);
        n_checks++;
        if (result !== er || carry !== ec || zero !== ez) begin
            n_errors++;
            $display("FAIL %s: got result=%0d carry=%b zero=%b, expected result=%0d carry=%b zero=%b",
                     nm, result, carry, zero, er, ec, ez);
        end
    endtask

    // Monitor: outputs are valid every cycle, so one expectation is retired per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_now(e.name, e.r, e.c, e.z);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int budget;
        n_checks = 0;
        n_errors = 0;
        clk_en   = 1'b0;
        rst      = 1'b0;
        a        = '0;
        b        = '0;
        opcode   = '0;

        // Reset with the clock stopped must still clear the outputs.
        #1 rst = 1'b1;
        #2 check_now("reset_no_clock", 4'd0, 1'b0, 1'b1);
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        issue(3, 5, 0, "add_3_5");
        issue(15, 1, 0, "add_wrap_15_1");
        issue(2, 7, 1, "sub_borrow_2_7");
        issue(9, 9, 1, "sub_equal_9_9");
        issue(4'b1100, 4'b1010, 2, "and");
        issue(4'b1100, 4'b1010, 3, "or");
        issue(4'b1100, 4'b1010, 4, "xor");
        issue(4'b1100, 4'b1010, 5, "not");
        issue(4'b1001, 0, 6, "shl_1001");
        issue(4'b1001, 0, 7, "shr_1001");
        issue(0, 1, 1, "sub_0_1");

        for (int i = 0; i < 10; i++) begin
            int av;
            int bv;
            int op;
            av = $urandom_range(0, 15);
            bv = $urandom_range(0, 15);
            op = $urandom_range(0, 7);
            issue(av, bv, op, $sformatf("rand_%0d", i));
        end

        budget = 20;
        while (sb_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        if (sb_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
            sb_q.delete();
        end

        // Load a non-zero result, then reset between edges; the op is discarded.
        @(negedge clk);
        a      = 4'd7;
        b      = 4'd1;
        opcode = 3'b000;
        @(posedge clk);
        #1 check_now("pre_reset_load", 4'd8, 1'b0, 1'b0);
        a      = 4'd15;
        b      = 4'd15;
        #1 rst = 1'b1;
        #1 check_now("reset_mid_stream", 4'd0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1 check_now("reset_held", 4'd0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
